// File: rtl/ddr_rd_pkg.sv
// ddr_rd_pkg: shared types and helpers for the DDR read capture path.
// Holds the capture FSM states and the per-burst capture-edge count.
package ddr_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    BURST
  } state_t;

  localparam int BEATS_PER_SCLK = 2;

  // Capture edges per burst; SWAP needs one extra edge to prime the hold.
  function automatic logic [3:0] ncap(input int bl, input logic swap);
    return 4'(bl / BEATS_PER_SCLK) + {3'b000, swap};
  endfunction

endpackage

// File: rtl/ddr_rd_beat_pack.sv
// ddr_rd_beat_pack: shift register plus hold register for read beats.
// Appends two beats per enable; with swap, pairs previous N with current P.
module ddr_rd_beat_pack
  import ddr_rd_pkg::*;
#(
  parameter int DW = 8,
  parameter int BL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             first,
  input  logic             swap,
  input  logic [DW-1:0]    din_p,
  input  logic [DW-1:0]    din_n,
  output logic [DW*BL-1:0] data_nxt
);

  localparam int W  = DW * BL;
  localparam int PW = DW * BEATS_PER_SCLK;

  logic [W-1:0]  sh;
  logic [DW-1:0] hold;
  logic [DW-1:0] b0;
  logic [DW-1:0] b1;

  // Pick the beat pair for this edge and form the shifted word.
  always_comb begin
    b0       = swap ? hold : din_p;
    b1       = swap ? din_p : din_n;
    data_nxt = {b1, b0, sh[W-1:PW]};
  end

  // Newest pair enters at the top so beat 0 ends up in the LSBs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh   <= '0;
      hold <= '0;
    end else if (en) begin
      hold <= din_n;
      if (!(first && swap))
        sh <= data_nxt;
    end
  end

endmodule

// File: rtl/ddr_rd_capture.sv
// ddr_rd_capture: times and assembles one DDR read burst into a wide word.
// Define DDR_RD_CAPTURE_STATS_EN to add BURST_CNT/ERR_CNT counters.
module ddr_rd_capture
  import ddr_rd_pkg::*;
#(
  parameter int DW = 8,
  parameter int BL = 8,
  parameter int LW = 4
) (
  input  logic             SCLK,
  input  logic             RST,
  input  logic             RD_CMD,
  input  logic [LW-1:0]    RD_LAT,
  input  logic             SWAP,
  input  logic [DW-1:0]    DIN_P,
  input  logic [DW-1:0]    DIN_N,
  input  logic             DQS_VALID,
  output logic [DW*BL-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             RD_ERR,
  output logic             CMD_OVF,
  output logic             BUSY
`ifdef DDR_RD_CAPTURE_STATS_EN
  ,
  output logic [15:0]      BURST_CNT,
  output logic [15:0]      ERR_CNT
`endif
);

  state_t          state;
  logic [LW-1:0]   lat_cnt;
  logic [3:0]      cap_left;
  logic            swap_q;
  logic            err_acc;
  logic            cap_en;
  logic            cap_first;
  logic [DW*BL-1:0] pack_nxt;

  assign cap_first = (state == LAT) && (lat_cnt == LW'(1));
  assign cap_en    = cap_first || (state == BURST);

  ddr_rd_beat_pack #(
    .DW(DW),
    .BL(BL)
  ) u_pack (
    .clk      (SCLK),
    .rst      (RST),
    .en       (cap_en),
    .first    (cap_first),
    .swap     (swap_q),
    .din_p    (DIN_P),
    .din_n    (DIN_N),
    .data_nxt (pack_nxt)
  );

  // Command, latency and burst sequencing with registered outputs.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      cap_left <= '0;
      swap_q   <= 1'b0;
      err_acc  <= 1'b0;
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
      RD_ERR   <= 1'b0;
      CMD_OVF  <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      RD_VALID <= 1'b0;
      RD_ERR   <= 1'b0;
      CMD_OVF  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (RD_CMD) begin
            lat_cnt <= (RD_LAT == '0) ? LW'(1) : RD_LAT;
            swap_q  <= SWAP;
            state   <= LAT;
            BUSY    <= 1'b1;
          end
        end
        LAT: begin
          CMD_OVF <= RD_CMD;
          if (lat_cnt == LW'(1)) begin
            cap_left <= ncap(BL, swap_q) - 4'd1;
            err_acc  <= ~DQS_VALID;
            state    <= BURST;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        BURST: begin
          CMD_OVF <= RD_CMD;
          err_acc <= err_acc | ~DQS_VALID;
          if (cap_left == 4'd1) begin
            RD_DATA  <= pack_nxt;
            RD_VALID <= 1'b1;
            RD_ERR   <= err_acc | ~DQS_VALID;
            state    <= IDLE;
            BUSY     <= 1'b0;
          end else begin
            cap_left <= cap_left - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DDR_RD_CAPTURE_STATS_EN
  logic [15:0] burst_cnt;
  logic [15:0] err_cnt;

  // Saturating completion and error counters.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      burst_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (RD_VALID && burst_cnt != 16'hFFFF)
        burst_cnt <= burst_cnt + 16'd1;
      if (RD_ERR && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

  assign BURST_CNT = burst_cnt;
  assign ERR_CNT   = err_cnt;
`endif

endmodule
